// File: rtl/rv_mem_pkg.sv
// Shared definitions for the unified-memory arbiter and LSU alignment logic:
// RV32I funct3 size/sign codes plus byte-enable and misalignment helpers.
package rv_mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    function automatic logic [3:0] be_encode(input logic [2:0] f3, input logic [1:0] off);
        logic [3:0] be;
        case (f3)
            F3_B, F3_BU: be = 4'b0001 << off;
            F3_H, F3_HU: be = 4'b0011 << off;
            F3_W:        be = 4'b1111;
            default:     be = 4'b0000;
        endcase
        return be;
    endfunction

    // Illegal funct3 codes are folded into the same error path as misalignment.
    function automatic logic data_misaligned(input logic [2:0] f3, input logic [1:0] off);
        logic err;
        case (f3)
            F3_B, F3_BU: err = 1'b0;
            F3_H, F3_HU: err = off[0];
            F3_W:        err = (off != 2'b00);
            default:     err = 1'b1;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/rv_lsu_align.sv
// Store lane replication / byte-enable generation and load lane extraction
// with sign or zero extension. Purely combinational.
module rv_lsu_align
    import rv_mem_pkg::*;
(
    input  logic [2:0]  st_funct3,
    input  logic [1:0]  st_off,
    input  logic [31:0] st_wdata,
    output logic [3:0]  st_be,
    output logic [31:0] st_lane_data,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_off,
    input  logic [31:0] ld_word,
    output logic [31:0] ld_data
);

    logic [31:0] shifted_s;

    // Store path: replicate the right-aligned datum across every lane it may occupy.
    always_comb begin
        st_be = be_encode(st_funct3, st_off);
        case (st_funct3)
            F3_B, F3_BU: st_lane_data = {4{st_wdata[7:0]}};
            F3_H, F3_HU: st_lane_data = {2{st_wdata[15:0]}};
            default:     st_lane_data = st_wdata;
        endcase
    end

    // Load path: move the addressed lane to bit 0, then extend per funct3.
    always_comb begin
        shifted_s = ld_word >> {ld_off, 3'b000};
        case (ld_funct3)
            F3_B:    ld_data = {{24{shifted_s[7]}}, shifted_s[7:0]};
            F3_BU:   ld_data = {24'h000000, shifted_s[7:0]};
            F3_H:    ld_data = {{16{shifted_s[15]}}, shifted_s[15:0]};
            F3_HU:   ld_data = {16'h0000, shifted_s[15:0]};
            F3_W:    ld_data = ld_word;
            default: ld_data = 32'h00000000;
        endcase
    end

endmodule

// File: rtl/rv_mem_arbiter.sv
// Arbitrates one pipelined single-port memory between instruction fetch and
// load/store: data-first priority with a streak limit that guarantees fetch progress.
module rv_mem_arbiter
    import rv_mem_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int MAX_DSTREAK = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [31:0]       i_rdata,
    output logic              i_err,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [2:0]        d_funct3,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    output logic              d_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_en,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    logic [3:0]  streak_r;
    logic [3:0]  streak_nxt_s;
    logic        i_gnt_s;
    logic        d_gnt_s;
    logic        i_err_s;
    logic        d_err_s;
    logic [3:0]  st_be_s;
    logic [31:0] st_lane_s;
    logic [31:0] ld_data_s;

    logic        rv_r;
    logic        owner_r;   // 1 = response belongs to the data port
    logic        err_r;
    logic        we_r;
    logic [2:0]  f3_r;
    logic [1:0]  off_r;

    assign i_err_s = (i_addr[1:0] != 2'b00);
    assign d_err_s = data_misaligned(d_funct3, d_addr[1:0]);

    rv_lsu_align u_align (
        .st_funct3    (d_funct3),
        .st_off       (d_addr[1:0]),
        .st_wdata     (d_wdata),
        .st_be        (st_be_s),
        .st_lane_data (st_lane_s),
        .ld_funct3    (f3_r),
        .ld_off       (off_r),
        .ld_word      (mem_rdata),
        .ld_data      (ld_data_s)
    );

    // Grant selection and next streak count.
    always_comb begin
        i_gnt_s      = 1'b0;
        d_gnt_s      = 1'b0;
        streak_nxt_s = streak_r;
        if (!rst_n) begin
            streak_nxt_s = 4'd0;
        end else if (d_req && (!i_req || (streak_r < 4'(MAX_DSTREAK)))) begin
            d_gnt_s = 1'b1;
        end else if (i_req) begin
            i_gnt_s = 1'b1;
        end else begin
            i_gnt_s = 1'b0;
        end
        if (!i_req || i_gnt_s) begin
            streak_nxt_s = 4'd0;
        end else if (d_gnt_s) begin
            streak_nxt_s = streak_r + 4'd1;
        end else begin
            streak_nxt_s = streak_r;
        end
    end

    // Memory port drive for the granted requester; erroneous requests never touch memory.
    always_comb begin
        mem_addr  = '0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_be    = 4'b0000;
        mem_wdata = 32'h00000000;
        if (d_gnt_s) begin
            mem_addr  = {d_addr[ADDR_W-1:2], 2'b00};
            mem_en    = !d_err_s;
            mem_we    = d_we && !d_err_s;
            mem_be    = (d_we && !d_err_s) ? st_be_s : 4'b0000;
            mem_wdata = (d_we && !d_err_s) ? st_lane_s : 32'h00000000;
        end else if (i_gnt_s) begin
            mem_addr = {i_addr[ADDR_W-1:2], 2'b00};
            mem_en   = !i_err_s;
        end else begin
            mem_en = 1'b0;
        end
    end

    // Response pipeline and streak register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            streak_r <= 4'd0;
            rv_r     <= 1'b0;
            owner_r  <= 1'b0;
            err_r    <= 1'b0;
            we_r     <= 1'b0;
            f3_r     <= 3'b000;
            off_r    <= 2'b00;
        end else begin
            streak_r <= streak_nxt_s;
            rv_r     <= i_gnt_s || d_gnt_s;
            owner_r  <= d_gnt_s;
            err_r    <= d_gnt_s ? d_err_s : i_err_s;
            we_r     <= d_gnt_s && d_we;
            f3_r     <= d_funct3;
            off_r    <= d_addr[1:0];
        end
    end

    assign i_gnt    = i_gnt_s;
    assign d_gnt    = d_gnt_s;
    assign i_rvalid = rv_r && !owner_r;
    assign d_rvalid = rv_r && owner_r;
    assign i_err    = i_rvalid && err_r;
    assign d_err    = d_rvalid && err_r;
    assign i_rdata  = (i_rvalid && !err_r) ? mem_rdata : 32'h00000000;
    assign d_rdata  = (d_rvalid && !err_r && !we_r) ? ld_data_s : 32'h00000000;

endmodule

// File: tb/tb_rv_mem_arbiter.sv
// Self-checking bench for rv_mem_arbiter: table of data ops, hand sequences for
// fetch, back-to-back, starvation and reset corners, and a response scoreboard.
module tb_rv_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_req, d_req, d_we;
    logic [15:0] i_addr, d_addr;
    logic [2:0]  d_funct3;
    logic [31:0] d_wdata;
    logic        i_gnt, i_rvalid, i_err, d_gnt, d_rvalid, d_err;
    logic [31:0] i_rdata, d_rdata;
    logic [15:0] mem_addr;
    logic        mem_en, mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata, mem_rdata;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [31:0] ram     [0:16383];
    logic [31:0] ref_mem [0:16383];

    typedef struct {
        logic        owner;
        logic        err;
        logic [31:0] rdata;
        int          cyc;
    } rsp_t;
    rsp_t sbq[$];

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic        en;
        logic [3:0]  be;
        logic [31:0] wd;
    } vec_t;
    vec_t tbl [16];

    rv_mem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid),
        .i_rdata(i_rdata), .i_err(i_err),
        .d_req(d_req), .d_we(d_we), .d_funct3(d_funct3), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .d_err(d_err),
        .mem_addr(mem_addr), .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Physical memory: synchronous read, byte-enabled write.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be[b]) ram[mem_addr[15:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
            end else begin
                mem_rdata <= ram[mem_addr[15:2]];
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic model_err(input logic [2:0] f3, input logic [1:0] off);
        if (f3 == 3'b000 || f3 == 3'b100) return 1'b0;
        if (f3 == 3'b001 || f3 == 3'b101) return off[0];
        if (f3 == 3'b010) return off != 2'b00;
        return 1'b1;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [31:0] w);
        logic [31:0] sh;
        logic [7:0]  b;
        logic [15:0] h;
        sh = w >> (8 * int'(off));
        b  = sh[7:0];
        h  = sh[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b100:  return {24'h0, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b101:  return {16'h0, h};
            3'b010:  return w;
            default: return 32'h0;
        endcase
    endfunction

    // Scoreboard: pop/compare responses, then push expectations for this cycle's grant.
    always @(negedge clk) begin
        rsp_t e;
        int   o;
        int   w;
        if (!rst_n) begin
            sbq.delete();
        end else begin
            if (i_rvalid && d_rvalid) chk("both_rvalid", 32'd1, 32'd0);
            if (i_rvalid || d_rvalid) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_rvalid", 32'd1, 32'd0);
                end else begin
                    e = sbq.pop_front();
                    chk("rsp_owner", 32'(d_rvalid), 32'(e.owner));
                    chk("rsp_latency", 32'(cyc), 32'(e.cyc + 1));
                    chk("rsp_err", 32'(d_rvalid ? d_err : i_err), 32'(e.err));
                    chk("rsp_rdata", d_rvalid ? d_rdata : i_rdata, e.rdata);
                end
            end else if (sbq.size() > 0 && cyc > sbq[0].cyc) begin
                void'(sbq.pop_front());
                chk("missing_rvalid", 32'd0, 32'd1);
            end
            if (i_gnt && d_gnt) chk("double_grant", 32'd1, 32'd0);
            if (d_gnt) begin
                o = int'(d_addr[1:0]);
                w = int'(d_addr[15:2]);
                e.owner = 1'b1;
                e.err   = model_err(d_funct3, d_addr[1:0]);
                e.cyc   = cyc;
                e.rdata = 32'h0;
                if (!e.err && !d_we) e.rdata = model_load(d_funct3, d_addr[1:0], ref_mem[w]);
                if (!e.err && d_we) begin
                    if (d_funct3 == 3'b000 || d_funct3 == 3'b100) ref_mem[w][8*o +: 8] = d_wdata[7:0];
                    else if (d_funct3 == 3'b010) ref_mem[w] = d_wdata;
                    else ref_mem[w][8*o +: 16] = d_wdata[15:0];
                end
                sbq.push_back(e);
            end else if (i_gnt) begin
                e.owner = 1'b0;
                e.err   = (i_addr[1:0] != 2'b00);
                e.cyc   = cyc;
                e.rdata = e.err ? 32'h0 : ref_mem[i_addr[15:2]];
                sbq.push_back(e);
            end
        end
    end

    task automatic chk_idle(input string tag);
        chk({tag, "_i_gnt"}, 32'(i_gnt), 32'd0);
        chk({tag, "_d_gnt"}, 32'(d_gnt), 32'd0);
        chk({tag, "_i_rvalid"}, 32'(i_rvalid), 32'd0);
        chk({tag, "_d_rvalid"}, 32'(d_rvalid), 32'd0);
        chk({tag, "_errs"}, 32'({i_err, d_err}), 32'd0);
        chk({tag, "_mem_en_we"}, 32'({mem_en, mem_we}), 32'd0);
        chk({tag, "_mem_be"}, 32'(mem_be), 32'd0);
        chk({tag, "_rdata"}, i_rdata | d_rdata, 32'd0);
    endtask

    initial begin
        string       seq;
        logic [7:0]  g;
        vec_t        v;

        for (int k = 0; k < 16384; k++) begin
            ref_mem[k] = 32'(k) * 32'h9E3779B1;
            ram[k]     <= 32'(k) * 32'h9E3779B1;
        end
        ref_mem[4] = 32'h00500093;
        ram[4]     <= 32'h00500093;

        tbl[0]  = '{1'b1, 3'b000, 16'h0102, 32'h000000F0, 1'b1, 4'b0100, 32'hF0F0F0F0};
        tbl[1]  = '{1'b0, 3'b000, 16'h0102, 32'h0,        1'b1, 4'b0000, 32'h0};
        tbl[2]  = '{1'b0, 3'b100, 16'h0102, 32'h0,        1'b1, 4'b0000, 32'h0};
        tbl[3]  = '{1'b1, 3'b001, 16'h0106, 32'h1234ABCD, 1'b1, 4'b1100, 32'hABCDABCD};
        tbl[4]  = '{1'b0, 3'b001, 16'h0106, 32'h0,        1'b1, 4'b0000, 32'h0};
        tbl[5]  = '{1'b0, 3'b101, 16'h0106, 32'h0,        1'b1, 4'b0000, 32'h0};
        tbl[6]  = '{1'b1, 3'b010, 16'h0108, 32'h80FF7F01, 1'b1, 4'b1111, 32'h80FF7F01};
        tbl[7]  = '{1'b0, 3'b010, 16'h0108, 32'h0,        1'b1, 4'b0000, 32'h0};
        tbl[8]  = '{1'b0, 3'b000, 16'h0109, 32'h0,        1'b1, 4'b0000, 32'h0};
        tbl[9]  = '{1'b0, 3'b000, 16'h010B, 32'h0,        1'b1, 4'b0000, 32'h0};
        tbl[10] = '{1'b0, 3'b010, 16'h0006, 32'h0,        1'b0, 4'b0000, 32'h0};
        tbl[11] = '{1'b1, 3'b001, 16'h0001, 32'h0000DEAD, 1'b0, 4'b0000, 32'h0};
        tbl[12] = '{1'b0, 3'b010, 16'h0000, 32'h0,        1'b1, 4'b0000, 32'h0};
        tbl[13] = '{1'b0, 3'b011, 16'h0010, 32'h0,        1'b0, 4'b0000, 32'h0};
        tbl[14] = '{1'b1, 3'b000, 16'h0103, 32'h0000005A, 1'b1, 4'b1000, 32'h5A5A5A5A};
        tbl[15] = '{1'b0, 3'b010, 16'h0100, 32'h0,        1'b1, 4'b0000, 32'h0};

        // Reset with both requesters active: nothing may be granted or driven.
        rst_n = 1'b0; i_req = 1'b1; i_addr = 16'h0010;
        d_req = 1'b1; d_we = 1'b1; d_funct3 = 3'b010; d_addr = 16'h0020; d_wdata = 32'h11111111;
        repeat (2) @(posedge clk);
        @(negedge clk) chk_idle("reset");
        @(posedge clk); #1 rst_n = 1'b1; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;

        // Fetch alone, aligned then misaligned.
        @(negedge clk) chk("first_cycle_no_rvalid", 32'(i_rvalid | d_rvalid), 32'd0);
        @(posedge clk); #1 i_req = 1'b1; i_addr = 16'h0010;
        @(negedge clk);
        chk("fetch_gnt", 32'(i_gnt), 32'd1);
        chk("fetch_mem_en", 32'({mem_en, mem_we}), 32'b10);
        chk("fetch_mem_addr", 32'(mem_addr), 32'h0010);
        @(posedge clk); #1 i_addr = 16'h0012;
        @(negedge clk);
        chk("fetch_rvalid", 32'(i_rvalid), 32'd1);
        chk("fetch_rdata", i_rdata, 32'h00500093);
        chk("fetch_misalign_gnt", 32'(i_gnt), 32'd1);
        chk("fetch_misalign_mem_en", 32'(mem_en), 32'd0);
        @(posedge clk); #1 i_req = 1'b0;
        @(negedge clk);
        chk("fetch_misalign_err", 32'(i_err), 32'd1);
        chk("fetch_misalign_rdata", i_rdata, 32'd0);

        // Table of data operations, issued back to back.
        for (int t = 0; t < 16; t++) begin
            v = tbl[t];
            @(posedge clk); #1
            d_req = 1'b1; d_we = v.we; d_funct3 = v.f3; d_addr = v.addr; d_wdata = v.wdata;
            @(negedge clk);
            chk($sformatf("tbl%0d_gnt", t), 32'(d_gnt), 32'd1);
            chk($sformatf("tbl%0d_mem_en", t), 32'(mem_en), 32'(v.en));
            chk($sformatf("tbl%0d_mem_we", t), 32'(mem_we), 32'(v.we && v.en));
            if (v.en) chk($sformatf("tbl%0d_mem_addr", t), 32'(mem_addr), 32'({v.addr[15:2], 2'b00}));
            if (v.we && v.en) begin
                chk($sformatf("tbl%0d_mem_be", t), 32'(mem_be), 32'(v.be));
                chk($sformatf("tbl%0d_mem_wdata", t), mem_wdata, v.wd);
            end
        end
        @(posedge clk); #1 d_req = 1'b0; d_we = 1'b0;
        @(negedge clk);
        chk("ram_word0_unchanged", ram[0], ref_mem[0]);
        chk("ram_word_0x100", ram[16'h0040], ref_mem[16'h0040]);

        // Back-to-back: fetch in N, load in N+1.
        @(posedge clk); #1 i_req = 1'b1; i_addr = 16'h0010;
        @(negedge clk) chk("b2b_i_gnt", 32'(i_gnt), 32'd1);
        @(posedge clk); #1 i_req = 1'b0; d_req = 1'b1; d_we = 1'b0; d_funct3 = 3'b010; d_addr = 16'h0108;
        @(negedge clk);
        chk("b2b_d_gnt", 32'(d_gnt), 32'd1);
        chk("b2b_rv_n1", 32'({i_rvalid, d_rvalid}), 32'b10);
        @(posedge clk); #1 d_req = 1'b0;
        @(negedge clk) chk("b2b_rv_n2", 32'({i_rvalid, d_rvalid}), 32'b01);

        // Starvation guard with both requests held.
        seq = "DDDDIDDDDI";
        @(posedge clk); #1 i_req = 1'b1; d_req = 1'b1; d_addr = 16'h0100;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            g = d_gnt ? "D" : (i_gnt ? "I" : "-");
            chk($sformatf("starve_seq%0d", i), 32'(g), 32'(seq.getc(i)));
        end
        @(posedge clk); #1 i_req = 1'b0; d_req = 1'b0;

        // Reset right after a load grant with streak at 3: response dropped, streak cleared.
        @(posedge clk); #1 i_req = 1'b1; d_req = 1'b1; d_addr = 16'h0108;
        repeat (3) @(negedge clk);
        chk("rst_pre_d_gnt", 32'(d_gnt), 32'd1);
        #1 rst_n = 1'b0;
        @(negedge clk) chk_idle("midrst");
        @(posedge clk); #1 rst_n = 1'b1;
        seq = "DDDDI";
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 0) chk("post_rst_no_rvalid", 32'(i_rvalid | d_rvalid), 32'd0);
            g = d_gnt ? "D" : (i_gnt ? "I" : "-");
            chk($sformatf("post_rst_seq%0d", i), 32'(g), 32'(seq.getc(i)));
        end
        @(posedge clk); #1 i_req = 1'b0; d_req = 1'b0;

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rv_mem_arbiter.md
Name: rv_mem_arbiter

Overview:
Shares one single-ported, synchronous-read unified memory between the instruction-fetch requester and the load/store requester of the RV32I core. Sits between the core and the memory, replacing the separate IM/DM paths. Provides a req/gnt/rvalid handshake, byte-lane generation for SB/SH/SW, sign/zero extension for LB/LH/LBU/LHU/LW, and misalignment detection. Uses data-first priority with an anti-starvation counter for fetch.

Parameters:
ADDR_W, 16, byte-address width of both requesters and of the memory port
MAX_DSTREAK, 4, maximum consecutive data grants while a fetch is pending; range 1..15

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous reset, active low
i_req  in  1  fetch request; held with i_addr until i_gnt
i_addr  in  ADDR_W  fetch byte address
i_gnt  out  1  fetch accepted this cycle
i_rvalid  out  1  fetch response valid; asserted one cycle after i_gnt
i_rdata  out  32  fetched instruction
i_err  out  1  misaligned fetch; qualified by i_rvalid
d_req  in  1  load/store request; held stable until d_gnt
d_we  in  1  1 = store, 0 = load
d_funct3  in  3  RV32I size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
d_addr  in  ADDR_W  data byte address
d_wdata  in  32  store data, right-aligned
d_gnt  out  1  data request accepted this cycle
d_rvalid  out  1  data response valid; one cycle after d_gnt (loads and stores)
d_rdata  out  32  extended load data; 0 for stores
d_err  out  1  misaligned or illegal funct3; qualified by d_rvalid
mem_addr  out  ADDR_W  word-aligned address (bits[1:0] = 00)
mem_en  out  1  memory access this cycle
mem_we  out  1  write strobe
mem_be  out  4  byte enables
mem_wdata  out  32  lane-shifted write data
mem_rdata  in  32  read data; valid the cycle after mem_en with mem_we = 0

Behaviour:
- Reset (rst_n = 0 at a rising edge): i_gnt, d_gnt, i_rvalid, d_rvalid, i_err, d_err, mem_en, mem_we = 0. mem_be = 0. Rdata outputs = 0. Streak counter = 0. Response pipeline registers are cleared.
- Reset during an operation: any response in flight is dropped. No rvalid is asserted on the first cycle after reset deasserts.
- Grant rules are combinational from the inputs and the registered streak count. At most one grant per cycle.
- Back-to-back grants are allowed on every cycle. The memory is pipelined: grant in cycle N, response in cycle N+1.
- Arbitration:
  - Only one requester active: that requester is granted.
  - Both active and streak < MAX_DSTREAK: data is granted, streak += 1.
  - Both active and streak == MAX_DSTREAK: fetch is granted, streak = 0.
  - Streak is cleared whenever i_req = 0 or fetch is granted.
- Misalignment:
  - Fetch: i_addr[1:0] != 0.
  - Data: H/HU with addr[0] = 1; W with addr[1:0] != 0.
  - Illegal funct3 (011, 110, 111) is treated as an error.
  - On an error the request is still granted, but mem_en = 0 and nothing is written. The response arrives next cycle with err = 1 and rdata = 0.
- Stores:
  - mem_en = mem_we = 1 in the grant cycle.
  - be: B = 0001 << off; H = 0011 << off; W = 1111.
  - mem_wdata = d_wdata replicated per size (byte ×4, half ×2).
- Loads:
  - funct3 and addr[1:0] are registered at grant.
  - Next cycle the selected lane is extracted and sign-extended (B, H) or zero-extended (BU, HU, W).
- A fetch response never appears in the same cycle as a data response from the same grant slot. Each response is tagged by a registered owner bit.

Decomposition:
- Shared package rv_mem_pkg: funct3 size/sign constants (F3_B, F3_H, F3_W, F3_BU, F3_HU) and the byte-enable encoding helper.
- One natural sub-module, rv_lsu_align: combinational store lane/be generation plus load extraction/extension. Reused by the future cache controller.

Test Plan:
- Fetch alone: i_req = 1, i_addr = 0x0010, mem word 0x00500093 -> i_gnt same cycle; next cycle i_rvalid = 1, i_rdata = 0x00500093, i_err = 0.
- Store byte then sign-extended load: SB d_addr = 0x0102, d_wdata = 0x000000F0 -> mem_be = 0100, mem_wdata = 0xF0F0F0F0. Then LB 0x0102 -> d_rdata = 0xFFFFFFF0; LBU -> 0x000000F0.
- Misaligned: LW d_addr = 0x0006 -> d_gnt, mem_en = 0; next cycle d_rvalid = 1, d_err = 1, d_rdata = 0. SH at 0x0001 -> no write (memory unchanged).
- Starvation: MAX_DSTREAK = 4, both req held continuously -> grant sequence D,D,D,D,I,D,D,D,D,I.
- Back-to-back: fetch grant in cycle N, load grant in N+1 -> i_rvalid in N+1, d_rvalid in N+2; never both in one cycle.
- Reset mid-op: rst_n = 0 in the cycle after a load grant -> no d_rvalid afterwards; all outputs 0; streak = 0.
